// File: rtl/alu_8bit.sv
// rtl/alu_8bit.sv - registered two-operand ALU (add/sub/and/or) with status flags
module alu_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       operation,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_t;

  op_t              op;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] res_next;
  logic             carry_next;
  logic             ovf_next;
  logic             a_sign;
  logic             b_sign;

  assign op     = op_t'(operation);
  assign a_sign = a[WIDTH-1];
  assign b_sign = b[WIDTH-1];

  // Extended-width arithmetic; the top bit is carry-out for add and borrow for sub.
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
  end

  // Select the result and arithmetic flags for the current opcode; every code is defined.
  always_comb begin
    res_next   = '0;
    carry_next = 1'b0;
    ovf_next   = 1'b0;
    case (op)
      OP_ADD: begin
        res_next   = sum_ext[WIDTH-1:0];
        carry_next = sum_ext[WIDTH];
        ovf_next   = (a_sign == b_sign) && (sum_ext[WIDTH-1] != a_sign);
      end
      OP_SUB: begin
        res_next   = diff_ext[WIDTH-1:0];
        carry_next = diff_ext[WIDTH];
        ovf_next   = (a_sign != b_sign) && (diff_ext[WIDTH-1] != a_sign);
      end
      OP_AND: begin
        res_next = a & b;
      end
      OP_OR: begin
        res_next = a | b;
      end
      default: begin
        res_next = '0;
      end
    endcase
  end

  // Valid strobe tracks in_valid one cycle later; cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

  // Result and flags load only on a valid strobe, otherwise they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else if (in_valid) begin
      result   <= res_next;
      carry    <= carry_next;
      overflow <= ovf_next;
      zero     <= (res_next == '0);
      negative <= res_next[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// tb/tb_alu_8bit.sv - directed self-checking bench for alu_8bit
module tb_alu_8bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] operation;
  logic       out_valid;
  logic [7:0] result;
  logic       carry;
  logic       overflow;
  logic       zero;
  logic       negative;

  int compared;
  int mismatched;

  alu_8bit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .operation (operation),
    .out_valid (out_valid),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Compare every output against hand-computed expectations.
  task automatic check_all(input string tag, input logic ev, input logic [7:0] er,
                           input logic ec, input logic eo, input logic ez, input logic en);
    check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, ev});
    check({tag, ".result"},    {8'd0, result},     {8'd0, er});
    check({tag, ".carry"},     {15'd0, carry},     {15'd0, ec});
    check({tag, ".overflow"},  {15'd0, overflow},  {15'd0, eo});
    check({tag, ".zero"},      {15'd0, zero},      {15'd0, ez});
    check({tag, ".negative"},  {15'd0, negative},  {15'd0, en});
  endtask

  // Drive one op at the falling edge, then sample just after the next rising edge.
  task automatic run_op(input logic [1:0] op, input logic [7:0] va, input logic [7:0] vb);
    @(negedge clk);
    in_valid  = 1'b1;
    operation = op;
    a         = va;
    b         = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'h5A;
    b        = 8'hA5;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    a          = 8'h00;
    b          = 8'h00;
    operation  = 2'b00;

    #3;
    check_all("reset_async", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("reset_held", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b00, 8'hCC, 8'hAA);
    check_all("add_cc_aa", 1'b1, 8'h76, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op(2'b01, 8'hCC, 8'hAA);
    check_all("sub_cc_aa", 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(2'b01, 8'h00, 8'h01);
    check_all("sub_00_01", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op(2'b10, 8'h55, 8'h33);
    check_all("and_55_33", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(2'b11, 8'hF0, 8'hCC);
    check_all("or_f0_cc", 1'b1, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(2'b10, 8'hF0, 8'h0F);
    check_all("and_f0_0f", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(2'b00, 8'h7F, 8'h01);
    check_all("add_7f_01", 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op(2'b00, 8'hFF, 8'h01);
    check_all("add_ff_01", 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op(2'b01, 8'h80, 8'h01);
    check_all("sub_80_01", 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);

    // Hold: no strobe keeps the last result and flags.
    idle_cycle();
    check_all("hold_1", 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    check_all("hold_2", 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back stream of four ops with in_valid held high.
    run_op(2'b00, 8'h10, 8'h20);
    check_all("b2b_0", 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(2'b01, 8'h10, 8'h20);
    check_all("b2b_1", 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op(2'b10, 8'hAA, 8'h0F);
    check_all("b2b_2", 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(2'b11, 8'h00, 8'h00);
    check_all("b2b_3", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycle();
    check_all("b2b_hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges, with an op in flight.
    run_op(2'b00, 8'hCC, 8'hAA);
    check_all("pre_reset", 1'b1, 8'h76, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("reset_mid", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(2'b00, 8'hFF, 8'hFF);
    check_all("reset_inflight", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_release_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(2'b01, 8'h05, 8'h03);
    check_all("post_release_op", 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    check_all("post_release_hold", 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
